// File: rtl/id_hazard_ctrl_if.sv
// ID-stage hazard controller bundle: decode/pipeline status in, stall/flush controls out.
interface id_hazard_ctrl_if;
  logic        valid_ID;
  logic [4:0]  rs1_addr_ID;
  logic [4:0]  rs2_addr_ID;
  logic        rs1_used_ID;
  logic        rs2_used_ID;
  logic [4:0]  rd_EX;
  logic        regwrite_EX;
  logic [4:0]  rd_MEM;
  logic        regwrite_MEM;
  logic        redirect_MEM;
  logic        en_PC;
  logic        en_IFID;
  logic        NOP_IFID;
  logic        en_IDEX;
  logic        NOP_IDEX;
  logic        NOP_EXMEM;
  logic        stall_timeout;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;

  modport master (
    output valid_ID, rs1_addr_ID, rs2_addr_ID, rs1_used_ID, rs2_used_ID,
           rd_EX, regwrite_EX, rd_MEM, regwrite_MEM, redirect_MEM,
    input  en_PC, en_IFID, NOP_IFID, en_IDEX, NOP_IDEX, NOP_EXMEM,
           stall_timeout, perf_stall_cnt, perf_flush_cnt
  );

  modport slave (
    input  valid_ID, rs1_addr_ID, rs2_addr_ID, rs1_used_ID, rs2_used_ID,
           rd_EX, regwrite_EX, rd_MEM, regwrite_MEM, redirect_MEM,
    output en_PC, en_IFID, NOP_IFID, en_IDEX, NOP_IDEX, NOP_EXMEM,
           stall_timeout, perf_stall_cnt, perf_flush_cnt
  );
endinterface

// File: rtl/id_hazard_ctrl.sv
// ID-stage RAW stall / redirect flush controller for the no-forwarding 5-stage pipeline.
// Define HAZ_PERF_EN to build the stall/flush performance counters.
module id_hazard_ctrl #(
  parameter int REDIRECT_BUBBLES = 1,
  parameter int MAX_STALL        = 15
) (
  input logic             clk_IDEX,
  input logic             rst_IDEX,
  id_hazard_ctrl_if.slave hz
);
  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_REDIR = 1'b1;

  logic [0:0] state;
  logic [2:0] bubble_cnt;
  logic [7:0] stall_run;
  logic       timeout_q;
  logic       hz1, hz2, hazard;
  logic [8:0] stall_inc;
  logic [5:0] ctrl;

  // WB is not compared: the register file writes in the first half-cycle.
  always_comb begin
    hz1 = hz.rs1_used_ID && (hz.rs1_addr_ID != 5'd0) &&
          ((hz.regwrite_EX  && (hz.rs1_addr_ID == hz.rd_EX)) ||
           (hz.regwrite_MEM && (hz.rs1_addr_ID == hz.rd_MEM)));
    hz2 = hz.rs2_used_ID && (hz.rs2_addr_ID != 5'd0) &&
          ((hz.regwrite_EX  && (hz.rs2_addr_ID == hz.rd_EX)) ||
           (hz.regwrite_MEM && (hz.rs2_addr_ID == hz.rd_MEM)));
    hazard    = hz.valid_ID && (hz1 || hz2);
    stall_inc = {1'b0, stall_run} + 9'd1;
  end

  // ctrl = {en_PC, en_IFID, en_IDEX, NOP_IFID, NOP_IDEX, NOP_EXMEM}
  always_comb begin
    ctrl = 6'b000000;
    if (!rst_IDEX) begin
      if (hz.redirect_MEM)      ctrl = 6'b111111;
      else if (state == ST_REDIR) ctrl = 6'b111110;
      else if (hazard)          ctrl = 6'b001010;
      else                      ctrl = 6'b111000;
    end
  end

  assign {hz.en_PC, hz.en_IFID, hz.en_IDEX, hz.NOP_IFID, hz.NOP_IDEX, hz.NOP_EXMEM} = ctrl;
  assign hz.stall_timeout = timeout_q;

  always_ff @(posedge clk_IDEX or posedge rst_IDEX) begin
    if (rst_IDEX) begin
      state      <= ST_RUN;
      bubble_cnt <= 3'd0;
      stall_run  <= 8'd0;
      timeout_q  <= 1'b0;
    end else if (hz.redirect_MEM) begin
      stall_run  <= 8'd0;
      bubble_cnt <= 3'(REDIRECT_BUBBLES);
      state      <= (REDIRECT_BUBBLES == 0) ? ST_RUN : ST_REDIR;
    end else if (state == ST_REDIR) begin
      stall_run  <= 8'd0;
      bubble_cnt <= bubble_cnt - 3'd1;
      if (bubble_cnt == 3'd1) state <= ST_RUN;
    end else if (hazard) begin
      if (stall_run != 8'hFF) stall_run <= stall_inc[7:0];
      if (stall_inc >= 9'(MAX_STALL)) timeout_q <= 1'b1;
    end else begin
      stall_run <= 8'd0;
    end
  end

`ifdef HAZ_PERF_EN
  logic [31:0] perf_stall_q, perf_flush_q;
  logic        stall_applied;

  assign stall_applied     = !hz.redirect_MEM && (state == ST_RUN) && hazard;
  assign hz.perf_stall_cnt = perf_stall_q;
  assign hz.perf_flush_cnt = perf_flush_q;

  always_ff @(posedge clk_IDEX or posedge rst_IDEX) begin
    if (rst_IDEX) begin
      perf_stall_q <= 32'd0;
      perf_flush_q <= 32'd0;
    end else begin
      if (stall_applied) perf_stall_q <= perf_stall_q + 32'd1;
      if (ctrl[2])       perf_flush_q <= perf_flush_q + 32'd1;
    end
  end
`else
  assign hz.perf_stall_cnt = 32'd0;
  assign hz.perf_flush_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed bench: two controllers (1 and 3 redirect bubbles) driven by the same stimulus.
module tb_id_hazard_ctrl;
  logic clk_IDEX = 1'b0;
  logic rst_IDEX = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

`ifdef HAZ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [5:0] C_OFF   = 6'b000000;
  localparam logic [5:0] C_RUN   = 6'b111000;
  localparam logic [5:0] C_STALL = 6'b001010;
  localparam logic [5:0] C_RDR   = 6'b111111;
  localparam logic [5:0] C_BUB   = 6'b111110;

  always #5 clk_IDEX = ~clk_IDEX;

  id_hazard_ctrl_if hif1 ();
  id_hazard_ctrl_if hif3 ();

  assign hif3.valid_ID     = hif1.valid_ID;
  assign hif3.rs1_addr_ID  = hif1.rs1_addr_ID;
  assign hif3.rs2_addr_ID  = hif1.rs2_addr_ID;
  assign hif3.rs1_used_ID  = hif1.rs1_used_ID;
  assign hif3.rs2_used_ID  = hif1.rs2_used_ID;
  assign hif3.rd_EX        = hif1.rd_EX;
  assign hif3.regwrite_EX  = hif1.regwrite_EX;
  assign hif3.rd_MEM       = hif1.rd_MEM;
  assign hif3.regwrite_MEM = hif1.regwrite_MEM;
  assign hif3.redirect_MEM = hif1.redirect_MEM;

  id_hazard_ctrl #(.REDIRECT_BUBBLES(1), .MAX_STALL(15)) dut1 (
    .clk_IDEX(clk_IDEX), .rst_IDEX(rst_IDEX), .hz(hif1.slave));
  id_hazard_ctrl #(.REDIRECT_BUBBLES(3), .MAX_STALL(15)) dut3 (
    .clk_IDEX(clk_IDEX), .rst_IDEX(rst_IDEX), .hz(hif3.slave));

  logic [5:0] c1, c3;
  assign c1 = {hif1.en_PC, hif1.en_IFID, hif1.en_IDEX, hif1.NOP_IFID, hif1.NOP_IDEX, hif1.NOP_EXMEM};
  assign c3 = {hif3.en_PC, hif3.en_IFID, hif3.en_IDEX, hif3.NOP_IFID, hif3.NOP_IDEX, hif3.NOP_EXMEM};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_IDEX);
    #1;
  endtask

  task automatic idle();
    hif1.valid_ID = 1'b0; hif1.rs1_addr_ID = 5'd0; hif1.rs2_addr_ID = 5'd0;
    hif1.rs1_used_ID = 1'b0; hif1.rs2_used_ID = 1'b0;
    hif1.rd_EX = 5'd0; hif1.regwrite_EX = 1'b0;
    hif1.rd_MEM = 5'd0; hif1.regwrite_MEM = 1'b0;
    hif1.redirect_MEM = 1'b0;
  endtask

  // rs1 = x5 against EX rd = x5
  task automatic ex_hazard();
    hif1.valid_ID = 1'b1; hif1.rs1_used_ID = 1'b1; hif1.rs1_addr_ID = 5'd5;
    hif1.rd_EX = 5'd5; hif1.regwrite_EX = 1'b1;
  endtask

  initial begin
    idle();
    hif1.redirect_MEM = 1'b1;
    #1;
    chk("reset_ctrl", 32'(c1), 32'(C_OFF));
    chk("reset_timeout", 32'(hif1.stall_timeout), 32'd0);
    chk("reset_perf_stall", hif1.perf_stall_cnt, 32'd0);
    chk("reset_perf_flush", hif1.perf_flush_cnt, 32'd0);
    hif1.redirect_MEM = 1'b0;
    tick(); tick();
    rst_IDEX = 1'b0;
    #1;
    chk("idle_run", 32'(c1), 32'(C_RUN));
    tick();

    // 1: EX hazard, then same rd in MEM, then clear
    ex_hazard(); #1;
    chk("t1_ex_stall", 32'(c1), 32'(C_STALL));
    tick();
    hif1.regwrite_EX = 1'b0; hif1.rd_EX = 5'd0; hif1.rd_MEM = 5'd5; hif1.regwrite_MEM = 1'b1; #1;
    chk("t1_mem_stall", 32'(c1), 32'(C_STALL));
    tick();
    hif1.regwrite_MEM = 1'b0; #1;
    chk("t1_release", 32'(c1), 32'(C_RUN));
    chk("t1_timeout", 32'(hif1.stall_timeout), 32'd0);
    tick();

    // 2: x0 never hazards; unused rs2 never hazards; used rs2 does
    idle(); hif1.valid_ID = 1'b1; hif1.rs2_used_ID = 1'b1; hif1.rs2_addr_ID = 5'd0;
    hif1.rd_EX = 5'd0; hif1.regwrite_EX = 1'b1; #1;
    chk("t2_x0", 32'(c1), 32'(C_RUN));
    tick();
    hif1.rs2_used_ID = 1'b0; hif1.rs2_addr_ID = 5'd7; hif1.rd_EX = 5'd7; #1;
    chk("t2_unused", 32'(c1), 32'(C_RUN));
    tick();
    hif1.rs2_used_ID = 1'b1; #1;
    chk("t2_rs2_stall", 32'(c1), 32'(C_STALL));
    tick();
    idle(); #1;
    tick();

    // 3: single redirect pulse
    hif1.redirect_MEM = 1'b1; #1;
    chk("t3_c0_b1", 32'(c1), 32'(C_RDR));
    chk("t3_c0_b3", 32'(c3), 32'(C_RDR));
    tick();
    hif1.redirect_MEM = 1'b0; #1;
    chk("t3_c1_b1", 32'(c1), 32'(C_BUB));
    chk("t3_c1_b3", 32'(c3), 32'(C_BUB));
    tick(); #1;
    chk("t3_c2_b1", 32'(c1), 32'(C_RUN));
    chk("t3_c2_b3", 32'(c3), 32'(C_BUB));
    tick(); #1;
    chk("t3_c3_b3", 32'(c3), 32'(C_BUB));
    tick(); #1;
    chk("t3_c4_b3", 32'(c3), 32'(C_RUN));
    tick();

    // 4: redirect beats hazard; REDIR ignores hazard; re-redirect reloads count
    ex_hazard(); hif1.redirect_MEM = 1'b1; #1;
    chk("t4_rdr_hz_b1", 32'(c1), 32'(C_RDR));
    chk("t4_rdr_hz_b3", 32'(c3), 32'(C_RDR));
    tick();
    hif1.redirect_MEM = 1'b0; #1;
    chk("t4_redir_ignores_hz", 32'(c1), 32'(C_BUB));
    tick();
    idle(); hif1.redirect_MEM = 1'b1; #1;
    chk("t4_second_rdr", 32'(c3), 32'(C_RDR));
    tick();
    hif1.redirect_MEM = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("t4_bubble%0d", i), 32'(c3), 32'(C_BUB));
      tick();
    end
    #1;
    chk("t4_done_b3", 32'(c3), 32'(C_RUN));
    chk("t4_done_b1", 32'(c1), 32'(C_RUN));
    tick();

    // 5: 15 consecutive stalls set the sticky timeout
    ex_hazard();
    for (int i = 0; i < 15; i++) begin
      #1;
      chk($sformatf("t5_stall%0d", i), 32'(c1), 32'(C_STALL));
      chk($sformatf("t5_to_low%0d", i), 32'(hif1.stall_timeout), 32'd0);
      tick();
    end
    chk("t5_to_set", 32'(hif1.stall_timeout), 32'd1);
    idle(); #1;
    chk("t5_to_sticky_run", 32'(c1), 32'(C_RUN));
    tick();
    chk("t5_to_sticky", 32'(hif1.stall_timeout), 32'd1);
    rst_IDEX = 1'b1; #1;
    chk("t5_to_reset", 32'(hif1.stall_timeout), 32'd0);
    rst_IDEX = 1'b0;
    tick();

    // 6: perf counters, then reset mid-REDIR
    ex_hazard();
    tick(); tick(); tick();
    idle(); hif1.redirect_MEM = 1'b1; #1;
    tick();
    hif1.redirect_MEM = 1'b0;
    tick(); #1;
    chk("t6_perf_stall", hif1.perf_stall_cnt, PERF ? 32'd3 : 32'd0);
    chk("t6_perf_flush", hif1.perf_flush_cnt, PERF ? 32'd2 : 32'd0);
    chk("t6_b3_in_redir", 32'(c3), 32'(C_BUB));
    chk("t6_b3_flush", hif3.perf_flush_cnt, PERF ? 32'd2 : 32'd0);
    rst_IDEX = 1'b1; #1;
    chk("t6_rst_ctrl", 32'(c3), 32'(C_OFF));
    chk("t6_rst_stall", hif3.perf_stall_cnt, 32'd0);
    chk("t6_rst_flush", hif3.perf_flush_cnt, 32'd0);
    rst_IDEX = 1'b0; #1;
    chk("t6_run_after_rst", 32'(c3), 32'(C_RUN));
    tick(); #1;
    chk("t6_run_next", 32'(c3), 32'(C_RUN));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
